execute_stage_muldiv: RTL and testbench

- Next-generation RV32 execute stage. Keeps forwarding muxes, ALU operand muxes, branch/jump resolution and the existing ALU instance.
- Adds an iterative multi-cycle RV32M multiply/divide unit, with a stall handshake toward the fetch/decode/execute pipes and a hold handshake from the memory stage.
- Branch compares are correctly signed for BLT/BGE. Width is parametrised.

---
 rtl/rv32i_types_pkg.sv | 38 +++
 rtl/alu.sv | 33 +++
 rtl/muldiv_unit.sv | 152 +++++++++++++++
 rtl/execute_stage_muldiv.sv | 111 +++++++++++
 tb/tb_execute_stage_muldiv.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_types_pkg.sv
// Shared RV32 execute-stage types: ALU/branch/forwarding encodings,
// RV32M operation codes, multiply/divide FSM states and PC source codes.
package rv32i_types_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } ALU_op_enum;

    typedef enum logic [2:0] {
        COND_EQ, COND_NE, COND_LOWER, COND_GREATER_OR_EQUAL,
        COND_LOWER_UNSIGNED, COND_GREATER_OR_EQUAL_UNSIGNED, COND_NONE
    } cond_code_enum;

    typedef enum logic [1:0] {
        FORWARD_RS, FORWARD_M, FORWARD_W, FORWARD_NONE
    } forward_select_enum;

    typedef enum logic [1:0] { ALU_A_RS1, ALU_A_PC  } alu_a_select_enum;
    typedef enum logic [1:0] { ALU_B_RS2, ALU_B_IMM } alu_b_select_enum;

    typedef enum logic [2:0] {
        MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
        MD_DIV, MD_DIVU, MD_REM, MD_REMU
    } muldiv_op_enum;

    typedef enum logic [1:0] { MD_IDLE, MD_BUSY, MD_DONE } muldiv_state_enum;

    localparam logic [1:0] PC_SOURCE_PC_PLUS_4 = 2'b00;
    localparam logic [1:0] PC_SOURCE_BRANCH    = 2'b01;
    localparam logic [1:0] PC_SOURCE_JUMP      = 2'b10;

    // True for the divide/remainder family.
    function automatic logic is_div_op(muldiv_op_enum op);
        return (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
    endfunction

endpackage

// File: rtl/alu.sv
// Integer ALU used by the execute stage.
module alu import rv32i_types_pkg::*; #(
    parameter int DATA_WIDTH = 32
) (
    input  ALU_op_enum              op_i,
    input  logic [DATA_WIDTH-1:0]   a_i,
    input  logic [DATA_WIDTH-1:0]   b_i,
    output logic [DATA_WIDTH-1:0]   result_o
);
    localparam int SW = $clog2(DATA_WIDTH);

    logic [SW-1:0] shamt;
    assign shamt = b_i[SW-1:0];

    // Operation select; shifts use the low log2(width) bits of B.
    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD:    result_o = a_i + b_i;
            ALU_SUB:    result_o = a_i - b_i;
            ALU_SLL:    result_o = a_i << shamt;
            ALU_SLT:    result_o = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU:   result_o = {{(DATA_WIDTH-1){1'b0}}, (a_i < b_i)};
            ALU_XOR:    result_o = a_i ^ b_i;
            ALU_SRL:    result_o = a_i >> shamt;
            ALU_SRA:    result_o = $unsigned($signed(a_i) >>> shamt);
            ALU_OR:     result_o = a_i | b_i;
            ALU_AND:    result_o = a_i & b_i;
            ALU_PASS_B: result_o = b_i;
            default:    result_o = '0;
        endcase
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (IDLE/BUSY/DONE).
// Operands are reduced to magnitudes at accept; the sign is applied on output.
// MULDIV_FAST_MUL_EN: MUL* ops use a single-cycle multiplier instead of shift-add.
module muldiv_unit import rv32i_types_pkg::*; #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic                    kill_i,
    input  logic                    hold_i,
    input  muldiv_op_enum           op_i,
    input  logic [DATA_WIDTH-1:0]   a_i,
    input  logic [DATA_WIDTH-1:0]   b_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [DATA_WIDTH-1:0]   result_o
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] COUNT_INIT = CW'(DATA_WIDTH);
    localparam logic [W-1:0]  MIN_VALUE  = {1'b1, {(W-1){1'b0}}};

    muldiv_state_enum state_q, state_d;
    muldiv_op_enum    op_q, op_d;
    logic [CW-1:0]    count_q, count_d;
    logic [W-1:0]     operand_q, operand_d;   // multiplicand or divisor magnitude
    logic [2*W-1:0]   acc_q, acc_d;           // {high/remainder, low/quotient}
    logic             neg_q, neg_d;

    logic           sign_a, sign_b, div_by_zero, div_overflow, neg_accept, fast_mul;
    logic [W-1:0]   mag_a, mag_b;
    logic [2*W-1:0] fast_product, mul_next, div_next, signed_acc;
    logic [W:0]     mul_sum, div_top, div_diff;
    logic [W-1:0]   rem_out;

    assign sign_a = a_i[W-1] & ((op_i == MD_MULH) || (op_i == MD_MULHSU) ||
                                (op_i == MD_DIV)  || (op_i == MD_REM));
    assign sign_b = b_i[W-1] & ((op_i == MD_MULH) || (op_i == MD_DIV) || (op_i == MD_REM));
    assign mag_a  = sign_a ? (~a_i + W'(1)) : a_i;
    assign mag_b  = sign_b ? (~b_i + W'(1)) : b_i;
    assign neg_accept   = (op_i == MD_REM) ? sign_a : (sign_a ^ sign_b);
    assign div_by_zero  = is_div_op(op_i) && (b_i == '0);
    assign div_overflow = ((op_i == MD_DIV) || (op_i == MD_REM)) &&
                          (a_i == MIN_VALUE) && (b_i == '1);

`ifdef MULDIV_FAST_MUL_EN
    assign fast_mul     = !is_div_op(op_i);
    assign fast_product = {{W{1'b0}}, mag_a} * {{W{1'b0}}, mag_b};
`else
    assign fast_mul     = 1'b0;
    assign fast_product = '0;
`endif

    // One shift-add step: conditionally add multiplicand to the high half, shift right.
    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, operand_q} : '0);
    assign mul_next = {mul_sum, acc_q[W-1:1]};
    // One restoring divide step: shift left, subtract divisor if it fits.
    assign div_top  = acc_q[2*W-1:W-1];
    assign div_diff = div_top - {1'b0, operand_q};
    assign div_next = div_diff[W] ? {div_top[W-1:0],  acc_q[W-2:0], 1'b0}
                                  : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};

    // State, counter and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MD_IDLE;
            op_q      <= MD_MUL;
            count_q   <= '0;
            operand_q <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            count_q   <= count_d;
            operand_q <= operand_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
        end
    end

    // Next-state logic: accept, iterate, then present the result until released.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        count_d   = count_q;
        operand_d = operand_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (start_i && !kill_i) begin
                    busy_o    = 1'b1;
                    op_d      = op_i;
                    count_d   = COUNT_INIT;
                    operand_d = mag_b;
                    neg_d     = neg_accept;
                    if (div_by_zero) begin
                        acc_d   = {a_i, {W{1'b1}}};
                        neg_d   = 1'b0;
                        state_d = MD_DONE;
                    end else if (div_overflow) begin
                        acc_d   = {{W{1'b0}}, a_i};
                        neg_d   = 1'b0;
                        state_d = MD_DONE;
                    end else if (fast_mul) begin
                        acc_d   = fast_product;
                        state_d = MD_DONE;
                    end else begin
                        acc_d   = {{W{1'b0}}, mag_a};
                        state_d = MD_BUSY;
                    end
                end
            end
            MD_BUSY: begin
                if (kill_i) begin
                    state_d = MD_IDLE;
                end else begin
                    busy_o  = 1'b1;
                    acc_d   = is_div_op(op_q) ? div_next : mul_next;
                    count_d = count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_d = MD_DONE;
                    end
                end
            end
            MD_DONE: begin
                done_o = 1'b1;
                if (kill_i || !hold_i) begin
                    state_d = MD_IDLE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    assign signed_acc = neg_q ? (~acc_q + (2*W)'(1)) : acc_q;
    assign rem_out    = neg_q ? (~acc_q[2*W-1:W] + W'(1)) : acc_q[2*W-1:W];

    // Result selection with the sign fixed up from the accept-time flag.
    always_comb begin
        result_o = '0;
        case (op_q)
            MD_MUL, MD_DIV, MD_DIVU:       result_o = signed_acc[W-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  result_o = signed_acc[2*W-1:W];
            default:                       result_o = rem_out;
        endcase
    end
endmodule

// File: rtl/execute_stage_muldiv.sv
// RV32 execute stage: forwarding and operand muxes, branch/jump resolution,
// ALU, and an iterative RV32M unit that stalls the front of the pipe.
// MULDIV_FAST_MUL_EN selects a single-cycle multiplier inside muldiv_unit.
module execute_stage_muldiv import rv32i_types_pkg::*; #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    jump_E,
    input  logic                    i_jump_E,
    input  logic                    branch_E,
    input  ALU_op_enum              ALU_op_E,
    input  cond_code_enum           cond_code_E,
    input  forward_select_enum      mux_forward_A_select_E,
    input  forward_select_enum      mux_forward_B_select_E,
    input  alu_a_select_enum        mux_ALU_operand_A_select_E,
    input  alu_b_select_enum        mux_ALU_operand_B_select_E,
    input  logic                    muldiv_valid_E,
    input  muldiv_op_enum           muldiv_op_E,
    input  logic                    hold_E,
    input  logic                    kill_E,
    input  logic [DATA_WIDTH-1:0]   rs1_data_E,
    input  logic [DATA_WIDTH-1:0]   rs2_data_E,
    input  logic [DATA_WIDTH-1:0]   ALU_result_M,
    input  logic [DATA_WIDTH-1:0]   ALU_result_W,
    input  logic [DATA_WIDTH-1:0]   PC_E,
    input  logic [DATA_WIDTH-1:0]   immediate_E,
    output logic [1:0]              PC_source_E,
    output logic                    flush_FD_E,
    output logic                    stall_E,
    output logic [DATA_WIDTH-1:0]   ALU_result_E,
    output logic [DATA_WIDTH-1:0]   mux_forward_B_out_E
);
    logic [DATA_WIDTH-1:0] fwd_a, fwd_b, operand_a, operand_b, alu_out, md_result;
    logic                  taken, md_busy, md_done;

    // Forwarding mux for source A.
    always_comb begin
        case (mux_forward_A_select_E)
            FORWARD_RS: fwd_a = rs1_data_E;
            FORWARD_M:  fwd_a = ALU_result_M;
            FORWARD_W:  fwd_a = ALU_result_W;
            default:    fwd_a = '0;
        endcase
    end

    // Forwarding mux for source B (also the store data).
    always_comb begin
        case (mux_forward_B_select_E)
            FORWARD_RS: fwd_b = rs2_data_E;
            FORWARD_M:  fwd_b = ALU_result_M;
            FORWARD_W:  fwd_b = ALU_result_W;
            default:    fwd_b = '0;
        endcase
    end
    assign mux_forward_B_out_E = fwd_b;

    // ALU operand selection; unknown selects fall back to the forwarded value.
    always_comb begin
        operand_a = (mux_ALU_operand_A_select_E == ALU_A_PC)  ? PC_E        : fwd_a;
        operand_b = (mux_ALU_operand_B_select_E == ALU_B_IMM) ? immediate_E : fwd_b;
    end

    // Branch condition on forwarded values; LOWER/GE are signed.
    always_comb begin
        case (cond_code_E)
            COND_EQ:                        taken = (fwd_a == fwd_b);
            COND_NE:                        taken = (fwd_a != fwd_b);
            COND_LOWER:                     taken = ($signed(fwd_a) <  $signed(fwd_b));
            COND_GREATER_OR_EQUAL:          taken = ($signed(fwd_a) >= $signed(fwd_b));
            COND_LOWER_UNSIGNED:            taken = (fwd_a <  fwd_b);
            COND_GREATER_OR_EQUAL_UNSIGNED: taken = (fwd_a >= fwd_b);
            default:                        taken = 1'b0;
        endcase
    end

    // Next-PC source; a stalled stage never redirects.
    always_comb begin
        PC_source_E = PC_SOURCE_PC_PLUS_4;
        if (!stall_E) begin
            if (jump_E || i_jump_E)     PC_source_E = PC_SOURCE_JUMP;
            else if (branch_E && taken) PC_source_E = PC_SOURCE_BRANCH;
        end
    end
    assign flush_FD_E = (PC_source_E != PC_SOURCE_PC_PLUS_4);

    alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .op_i     (ALU_op_E),
        .a_i      (operand_a),
        .b_i      (operand_b),
        .result_o (alu_out)
    );

    muldiv_unit #(.DATA_WIDTH(DATA_WIDTH)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (muldiv_valid_E),
        .kill_i   (kill_E),
        .hold_i   (hold_E),
        .op_i     (muldiv_op_E),
        .a_i      (fwd_a),
        .b_i      (fwd_b),
        .busy_o   (md_busy),
        .done_o   (md_done),
        .result_o (md_result)
    );

    assign stall_E = md_busy;
    // The muldiv result is only meaningful once the unit reports done.
    assign ALU_result_E = muldiv_valid_E ? (md_done ? md_result : '0) : alu_out;
endmodule

// File: tb/tb_execute_stage_muldiv.sv
// Self-checking bench for execute_stage_muldiv with a behavioural model.
module tb_execute_stage_muldiv;
    import rv32i_types_pkg::*;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic jump_E, i_jump_E, branch_E, muldiv_valid_E, hold_E, kill_E;
    ALU_op_enum         ALU_op_E;
    cond_code_enum      cond_code_E;
    forward_select_enum mux_forward_A_select_E, mux_forward_B_select_E;
    alu_a_select_enum   mux_ALU_operand_A_select_E;
    alu_b_select_enum   mux_ALU_operand_B_select_E;
    muldiv_op_enum      muldiv_op_E;
    logic [W-1:0] rs1_data_E, rs2_data_E, ALU_result_M, ALU_result_W, PC_E, immediate_E;
    logic [1:0]   PC_source_E;
    logic         flush_FD_E, stall_E;
    logic [W-1:0] ALU_result_E, mux_forward_B_out_E;

    execute_stage_muldiv #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .jump_E(jump_E), .i_jump_E(i_jump_E), .branch_E(branch_E),
        .ALU_op_E(ALU_op_E), .cond_code_E(cond_code_E),
        .mux_forward_A_select_E(mux_forward_A_select_E),
        .mux_forward_B_select_E(mux_forward_B_select_E),
        .mux_ALU_operand_A_select_E(mux_ALU_operand_A_select_E),
        .mux_ALU_operand_B_select_E(mux_ALU_operand_B_select_E),
        .muldiv_valid_E(muldiv_valid_E), .muldiv_op_E(muldiv_op_E),
        .hold_E(hold_E), .kill_E(kill_E),
        .rs1_data_E(rs1_data_E), .rs2_data_E(rs2_data_E),
        .ALU_result_M(ALU_result_M), .ALU_result_W(ALU_result_W),
        .PC_E(PC_E), .immediate_E(immediate_E),
        .PC_source_E(PC_source_E), .flush_FD_E(flush_FD_E), .stall_E(stall_E),
        .ALU_result_E(ALU_result_E), .mux_forward_B_out_E(mux_forward_B_out_E)
    );

    int checks = 0;
    int errors = 0;
    logic         chk_en = 1'b0;
    logic         exp_stall, exp_flush, exp_res_chk;
    logic [1:0]   exp_pcs;
    logic [W-1:0] exp_res, exp_fwdb;
    string        tag = "reset";

    // ---------------- behavioural model ----------------
    function automatic logic [W-1:0] m_fwd(forward_select_enum s, logic [W-1:0] rs);
        case (s)
            FORWARD_RS: return rs;
            FORWARD_M:  return ALU_result_M;
            FORWARD_W:  return ALU_result_W;
            default:    return '0;
        endcase
    endfunction

    function automatic logic [W-1:0] m_alu(ALU_op_enum op, logic [W-1:0] a, logic [W-1:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            ALU_ADD:    return a + b;
            ALU_SUB:    return a - b;
            ALU_SLL:    return a << sh;
            ALU_SLT:    return (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
            ALU_SLTU:   return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:    return a ^ b;
            ALU_SRL:    return a >> sh;
            ALU_SRA:    return $unsigned($signed(a) >>> sh);
            ALU_OR:     return a | b;
            ALU_AND:    return a & b;
            ALU_PASS_B: return b;
            default:    return '0;
        endcase
    endfunction

    function automatic logic m_taken(cond_code_enum c, logic [W-1:0] a, logic [W-1:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (c)
            COND_EQ:                        return a == b;
            COND_NE:                        return a != b;
            COND_LOWER:                     return sa < sb;
            COND_GREATER_OR_EQUAL:          return sa >= sb;
            COND_LOWER_UNSIGNED:            return a < b;
            COND_GREATER_OR_EQUAL_UNSIGNED: return a >= b;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic [W-1:0] m_muldiv(muldiv_op_enum op, logic [W-1:0] a, logic [W-1:0] b);
        longint sa, sb;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            MD_MUL:    begin p = sa * sb;          return p[31:0];  end
            MD_MULH:   begin p = sa * sb;          return p[63:32]; end
            MD_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            MD_MULHU:  begin p = ua * ub;          return p[63:32]; end
            MD_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            MD_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            MD_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int m_lat(muldiv_op_enum op, logic [W-1:0] a, logic [W-1:0] b);
        logic is_div, is_signed_div;
        is_div = (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
        is_signed_div = (op == MD_DIV) || (op == MD_REM);
        if (is_div && b == 0) return 1;
        if (is_signed_div && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        if (!is_div) return MUL_LAT;
        return W + 1;
    endfunction

    // Recompute combinational expectations from the current inputs.
    task automatic update_comb();
        logic [W-1:0] fa, fb, oa, ob;
        fa = m_fwd(mux_forward_A_select_E, rs1_data_E);
        fb = m_fwd(mux_forward_B_select_E, rs2_data_E);
        oa = (mux_ALU_operand_A_select_E == ALU_A_PC)  ? PC_E        : fa;
        ob = (mux_ALU_operand_B_select_E == ALU_B_IMM) ? immediate_E : fb;
        exp_fwdb = fb;
        if (exp_stall)                            exp_pcs = 2'b00;
        else if (jump_E || i_jump_E)              exp_pcs = 2'b10;
        else if (branch_E && m_taken(cond_code_E, fa, fb)) exp_pcs = 2'b01;
        else                                      exp_pcs = 2'b00;
        exp_flush = (exp_pcs != 2'b00);
        if (!muldiv_valid_E) begin
            exp_res     = m_alu(ALU_op_E, oa, ob);
            exp_res_chk = 1'b1;
        end else begin
            exp_res_chk = 1'b0;
        end
    endtask

    // ---------------- compare process ----------------
    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s/%s actual=%h required=%h t=%0t", tag, nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall",  {31'd0, stall_E},    {31'd0, exp_stall});
            chk("pcsrc",  {30'd0, PC_source_E}, {30'd0, exp_pcs});
            chk("flush",  {31'd0, flush_FD_E}, {31'd0, exp_flush});
            chk("fwdB",   mux_forward_B_out_E, exp_fwdb);
            if (exp_res_chk) chk("result", ALU_result_E, exp_res);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        muldiv_valid_E = 1'b0;
        hold_E = 1'b0;
        kill_E = 1'b0;
        exp_stall = 1'b0;
        update_comb();
    endtask

    task automatic run_muldiv(input string nm, input muldiv_op_enum op,
                              input logic [W-1:0] a, input logic [W-1:0] b,
                              input int hold_n, input logic [W-1:0] want, input int lat);
        tag = nm;
        $display("txn %s op=%0d a=%h b=%h hold=%0d expect=%h lat=%0d", nm, op, a, b, hold_n, want, lat);
        jump_E = 1'b0; i_jump_E = 1'b0; branch_E = 1'b0;
        mux_forward_A_select_E = FORWARD_RS;
        mux_forward_B_select_E = FORWARD_RS;
        rs1_data_E = a; rs2_data_E = b;
        muldiv_op_E = op;
        muldiv_valid_E = 1'b1;
        exp_stall = 1'b1;
        update_comb();
        repeat (lat) step();
        exp_stall = 1'b0;
        update_comb();
        exp_res = want;
        exp_res_chk = 1'b1;
        hold_E = (hold_n > 0);
        repeat (hold_n) step();
        hold_E = 1'b0;
        step();
        go_idle();
    endtask

    initial begin
        rst_n = 1'b0;
        jump_E = 0; i_jump_E = 0; branch_E = 0; muldiv_valid_E = 0; hold_E = 0; kill_E = 0;
        ALU_op_E = ALU_ADD; cond_code_E = COND_NONE; muldiv_op_E = MD_MUL;
        mux_forward_A_select_E = FORWARD_RS; mux_forward_B_select_E = FORWARD_RS;
        mux_ALU_operand_A_select_E = ALU_A_RS1; mux_ALU_operand_B_select_E = ALU_B_RS2;
        rs1_data_E = 0; rs2_data_E = 0; ALU_result_M = 0; ALU_result_W = 0; PC_E = 0; immediate_E = 0;
        exp_stall = 1'b0;
        update_comb();
        chk_en = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        tag = "fwd_add";
        $display("txn fwd_add M=0x10 imm=4");
        mux_forward_A_select_E = FORWARD_M; ALU_result_M = 32'h10;
        mux_ALU_operand_B_select_E = ALU_B_IMM; immediate_E = 32'd4; ALU_op_E = ALU_ADD;
        update_comb(); exp_res = 32'h14;
        step();

        tag = "blt";
        $display("txn blt -1 < 1");
        mux_forward_A_select_E = FORWARD_RS; mux_ALU_operand_B_select_E = ALU_B_RS2;
        rs1_data_E = 32'hFFFF_FFFF; rs2_data_E = 32'd1; branch_E = 1'b1; cond_code_E = COND_LOWER;
        update_comb(); exp_pcs = 2'b01; exp_flush = 1'b1;
        step();
        tag = "bltu";
        $display("txn bltu 0xffffffff < 1");
        cond_code_E = COND_LOWER_UNSIGNED;
        update_comb(); exp_pcs = 2'b00; exp_flush = 1'b0;
        step();
        branch_E = 1'b0;

        run_muldiv("mul_7_m3", MD_MUL,   32'd7, 32'hFFFF_FFFD, 0, 32'hFFFF_FFEB, MUL_LAT);
        run_muldiv("mulhu_max", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, MUL_LAT);
        run_muldiv("div_ovf",  MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 1);
        run_muldiv("rem_ovf",  MD_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0, 1);
        run_muldiv("divu_0",   MD_DIVU, 32'd5, 32'd0, 0, 32'hFFFF_FFFF, 1);
        run_muldiv("remu_0",   MD_REMU, 32'd5, 32'd0, 0, 32'd5, 1);
        run_muldiv("divu_hold", MD_DIVU, 32'd100, 32'd7, 3, 32'd14, W + 1);
        run_muldiv("div_neg",  MD_DIV,  32'hFFFF_FF9C, 32'd7, 1, 32'hFFFF_FFF2, W + 1);

        tag = "kill_busy";
        $display("txn kill_busy divu 1000/3");
        rs1_data_E = 32'd1000; rs2_data_E = 32'd3; muldiv_op_E = MD_DIVU;
        muldiv_valid_E = 1'b1; exp_stall = 1'b1; update_comb();
        repeat (6) step();
        kill_E = 1'b1; exp_stall = 1'b0; update_comb();
        step();
        go_idle();
        repeat (2) step();
        run_muldiv("after_kill", MD_REMU, 32'd1000, 32'd3, 0, 32'd1, W + 1);

        tag = "rst_busy";
        $display("txn rst_busy reset at count 10");
        rs1_data_E = 32'd1000; rs2_data_E = 32'd3; muldiv_op_E = MD_DIVU;
        muldiv_valid_E = 1'b1; exp_stall = 1'b1; update_comb();
        repeat (23) step();
        rst_n = 1'b0;
        go_idle();
        step();
        rst_n = 1'b1;
        step();
        run_muldiv("mul_after_rst", MD_MUL, 32'd12345, 32'd678, 0, 32'd8369910, MUL_LAT);

        for (int i = 0; i < 24; i++) begin
            muldiv_op_enum op;
            logic [W-1:0] a, b;
            int sel;
            op = muldiv_op_enum'($urandom_range(0, 7));
            a = $urandom; b = $urandom;
            sel = $urandom_range(0, 5);
            if (sel == 0) b = '0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) b = W'($urandom_range(1, 20));
            run_muldiv("rand_md", op, a, b, $urandom_range(0, 2), m_muldiv(op, a, b), m_lat(op, a, b));
        end

        for (int i = 0; i < 40; i++) begin
            tag = "rand_alu";
            ALU_op_E = ALU_op_enum'($urandom_range(0, 10));
            cond_code_E = cond_code_enum'($urandom_range(0, 6));
            mux_forward_A_select_E = forward_select_enum'($urandom_range(0, 3));
            mux_forward_B_select_E = forward_select_enum'($urandom_range(0, 3));
            mux_ALU_operand_A_select_E = alu_a_select_enum'($urandom_range(0, 1));
            mux_ALU_operand_B_select_E = alu_b_select_enum'($urandom_range(0, 1));
            jump_E = ($urandom_range(0, 5) == 0);
            i_jump_E = ($urandom_range(0, 5) == 0);
            branch_E = ($urandom_range(0, 1) == 0);
            rs1_data_E = $urandom; rs2_data_E = ($urandom_range(0, 3) == 0) ? rs1_data_E : $urandom;
            ALU_result_M = $urandom; ALU_result_W = $urandom; PC_E = $urandom; immediate_E = $urandom;
            update_comb();
            $display("txn rand_alu op=%0d cc=%0d a=%h b=%h exp=%h pcs=%0d", ALU_op_E, cond_code_E,
                     rs1_data_E, rs2_data_E, exp_res, exp_pcs);
            step();
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
